// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a byte-serial boot image (count, little-endian
// payload words, XOR checksum), writes each word into instruction memory and
// releases the processor from reset once the checksum matches.
module imem_boot_loader #(
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 i_mem_wr_en,
    output logic [BUS_WIDTH-1:0] i_mem_wr_addr,
    output logic [BUS_WIDTH-1:0] i_mem_wr_data,
    output logic                 cpu_rst_n,
    output logic                 load_done,
    output logic                 load_err,
    output logic [15:0]          words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERROR
    } state_t;

    state_t               state, state_n;

    logic [15:0]          count_q, count_n;
    logic [7:0]           csum_q, csum_n;
    logic [1:0]           byte_idx_q, byte_idx_n;
    logic [15:0]          word_idx_q, word_idx_n;
    logic [23:0]          lanes_q, lanes_n;
    logic                 wr_en_q, wr_en_n;
    logic [BUS_WIDTH-1:0] wr_addr_q, wr_addr_n;
    logic [BUS_WIDTH-1:0] wr_data_q, wr_data_n;
    logic [15:0]          wl_q, wl_n;
    logic                 done_q, err_q;
    logic                 accept;
    logic [15:0]          n_full;

    // Ready is a pure decode of the current state.
    always_comb begin
        rx_ready = (state == S_CNT_LO) || (state == S_CNT_HI) ||
                   (state == S_DATA)   || (state == S_CSUM);
    end

    assign accept        = rx_valid && rx_ready;
    assign n_full        = {rx_data, count_q[7:0]};

    assign i_mem_wr_en   = wr_en_q;
    assign i_mem_wr_addr = wr_addr_q;
    assign i_mem_wr_data = wr_data_q;
    assign words_loaded  = wl_q;
    assign load_done     = done_q;
    assign load_err      = err_q;
    assign cpu_rst_n     = done_q;

    // State register; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CNT_LO;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath next values for every accepted byte.
    always_comb begin
        state_n    = state;
        count_n    = count_q;
        csum_n     = csum_q;
        byte_idx_n = byte_idx_q;
        word_idx_n = word_idx_q;
        lanes_n    = lanes_q;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr_q;
        wr_data_n  = wr_data_q;
        wl_n       = wl_q;

        case (state)
            S_CNT_LO: begin
                if (accept) begin
                    count_n[7:0] = rx_data;
                    state_n      = S_CNT_HI;
                end
            end

            S_CNT_HI: begin
                if (accept) begin
                    count_n = n_full;
                    if ((n_full == '0) || (32'(n_full) > DEPTH_WORDS)) begin
                        state_n = S_ERROR;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    csum_n     = csum_q ^ rx_data;
                    byte_idx_n = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: lanes_n[7:0]   = rx_data;
                        2'd1: lanes_n[15:8]  = rx_data;
                        2'd2: lanes_n[23:16] = rx_data;
                        default: begin
                            // Fourth byte completes the word; lane 3 goes
                            // straight into the write data register.
                            wr_en_n    = 1'b1;
                            wr_addr_n  = BUS_WIDTH'({word_idx_q, 2'b00});
                            wr_data_n  = BUS_WIDTH'({rx_data, lanes_q});
                            word_idx_n = word_idx_q + 16'd1;
                            if (wl_q < count_q) begin
                                wl_n = wl_q + 16'd1;
                            end
                            if (word_idx_q == (count_q - 16'd1)) begin
                                state_n = S_CSUM;
                            end
                        end
                    endcase
                end
            end

            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_n = S_RUN;
                    end else begin
                        state_n = S_ERROR;
                    end
                end
            end

            default: begin
            end
        endcase
    end

    // Datapath and status registers; a reset in the same cycle as a
    // completed word suppresses the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            csum_q     <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            lanes_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wl_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_n;
            csum_q     <= csum_n;
            byte_idx_q <= byte_idx_n;
            word_idx_q <= word_idx_n;
            lanes_q    <= lanes_n;
            wr_en_q    <= wr_en_n;
            wr_addr_q  <= wr_addr_n;
            wr_data_q  <= wr_data_n;
            wl_q       <= wl_n;
            done_q     <= (state_n == S_RUN);
            err_q      <= (state_n == S_ERROR);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: table of frames checked against a
// byte-stream reference model, plus hand sequences for timing and reset.
module tb_imem_boot_loader;

    localparam int unsigned BW    = 32;
    localparam int unsigned DEPTH = 256;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          i_mem_wr_en;
    logic [BW-1:0] i_mem_wr_addr;
    logic [BW-1:0] i_mem_wr_data;
    logic          cpu_rst_n;
    logic          load_done;
    logic          load_err;
    logic [15:0]   words_loaded;

    imem_boot_loader #(
        .BUS_WIDTH   (BW),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_wr_addr (i_mem_wr_addr),
        .i_mem_wr_data (i_mem_wr_data),
        .cpu_rst_n     (cpu_rst_n),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_loaded  (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Captured writes {addr, data}; cleared whenever reset is seen.
    logic [63:0] got_q[$];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            got_q.delete();
        end else if (i_mem_wr_en) begin
            got_q.push_back({i_mem_wr_addr, i_mem_wr_data});
            check("wl_step", 128'(words_loaded), 128'(got_q.size()));
        end
    end

    // Reference model over a raw byte stream.
    logic [7:0]  frame_q[$];
    logic [63:0] exp_wr_q[$];
    bit          m_done, m_err;
    int          m_acc;

    task automatic model();
        int   n;
        logic [7:0] x;
        exp_wr_q.delete();
        m_done = 0; m_err = 0;
        n = int'(frame_q[0]) + 256 * int'(frame_q[1]);
        if (n == 0 || n > int'(DEPTH)) begin
            m_err = 1;
            m_acc = 2;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            logic [31:0] w;
            w = {frame_q[2+4*k+3], frame_q[2+4*k+2], frame_q[2+4*k+1], frame_q[2+4*k]};
            exp_wr_q.push_back({32'(4 * k), w});
            for (int b = 0; b < 4; b++) x = x ^ frame_q[2+4*k+b];
        end
        m_acc = 3 + 4 * n;
        if (x == frame_q[2+4*n]) m_done = 1;
        else m_err = 1;
    endtask

    task automatic build_frame(input logic [15:0] n, input int kind, input bit bad);
        int npay;
        logic [7:0] cs;
        logic [31:0] w;
        frame_q.delete();
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        npay = (n == 16'd0 || 32'(n) > DEPTH) ? 2 : int'(n);
        cs = 8'h00;
        for (int k = 0; k < npay; k++) begin
            case (kind)
                0:       w = (k == 0) ? 32'h00500093 : 32'h00000013;
                1:       w = $urandom;
                default: w = 32'(k);
            endcase
            for (int b = 0; b < 4; b++) begin
                frame_q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        frame_q.push_back(bad ? (cs ^ 8'h01) : cs);
        frame_q.push_back(8'($urandom));
        frame_q.push_back(8'($urandom));
    endtask

    // Presents every byte of frame_q once, with random idle gaps; counts
    // the bytes the loader actually took.
    task automatic send_frame(input int max_gap, output int nacc);
        nacc = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int c = 0; c < g; c++) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = frame_q[i];
            if (rx_ready) nacc++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check(nm, 128'({i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data, cpu_rst_n,
                        load_done, load_err, words_loaded, rx_ready}),
                  128'({1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1}));
    endtask

    task automatic compare_writes(input string nm);
        int m;
        check({nm, "_nwr"}, 128'(got_q.size()), 128'(exp_wr_q.size()));
        m = (got_q.size() < exp_wr_q.size()) ? got_q.size() : exp_wr_q.size();
        for (int i = 0; i < m; i++) check({nm, "_wr"}, 128'(got_q[i]), 128'(exp_wr_q[i]));
    endtask

    typedef struct {
        logic [15:0] n;
        int          kind;
        bit          bad;
        int          gap;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_wl;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int nacc;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        vecs[0] = '{16'd2,     0, 1'b0, 0, 1'b1, 1'b0, 16'd2};
        vecs[1] = '{16'd2,     0, 1'b1, 0, 1'b0, 1'b1, 16'd2};
        vecs[2] = '{16'd0,     0, 1'b0, 0, 1'b0, 1'b1, 16'd0};
        vecs[3] = '{16'd257,   1, 1'b0, 0, 1'b0, 1'b1, 16'd0};
        vecs[4] = '{16'd2,     0, 1'b0, 5, 1'b1, 1'b0, 16'd2};
        vecs[5] = '{16'd5,     1, 1'b0, 3, 1'b1, 1'b0, 16'd5};
        vecs[6] = '{16'd7,     1, 1'b1, 2, 1'b0, 1'b1, 16'd7};
        vecs[7] = '{16'd256,   2, 1'b0, 0, 1'b1, 1'b0, 16'd256};
        vecs[8] = '{16'd1,     1, 1'b0, 1, 1'b1, 1'b0, 16'd1};
        vecs[9] = '{16'hFFFF,  1, 1'b0, 0, 1'b0, 1'b1, 16'd0};

        for (int v = 0; v < 10; v++) begin
            reset_dut();
            check_reset_outputs("reset");
            build_frame(vecs[v].n, vecs[v].kind, vecs[v].bad);
            model();
            send_frame(vecs[v].gap, nacc);
            repeat (3) @(negedge clk);
            check("accepted", 128'(nacc), 128'(m_acc));
            check("load_done", 128'(load_done), 128'(vecs[v].exp_done));
            check("load_err", 128'(load_err), 128'(vecs[v].exp_err));
            check("cpu_rst_n", 128'(cpu_rst_n), 128'(vecs[v].exp_done));
            check("rx_ready_end", 128'(rx_ready), 128'(0));
            check("words_loaded", 128'(words_loaded), 128'(vecs[v].exp_wl));
            compare_writes("frame");
            if (vecs[v].n == 16'd256 && got_q.size() > 0)
                check("last_addr", 128'(got_q[got_q.size()-1][63:32]), 128'(32'h3FC));
        end

        // Nominal frame at one byte per cycle with cycle-exact output checks.
        reset_dut();
        build_frame(16'd2, 0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = frame_q[i];
            @(posedge clk);
            #2;
            if (i == 5) check("w0", 128'({i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data}),
                              128'({1'b1, 32'h0, 32'h00500093}));
            if (i == 9) check("w1", 128'({i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data, cpu_rst_n}),
                              128'({1'b1, 32'h4, 32'h00000013, 1'b0}));
            if (i == 10) check("release", 128'({i_mem_wr_en, cpu_rst_n, load_done, words_loaded}),
                               128'({1'b0, 1'b1, 1'b1, 16'd2}));
        end
        @(negedge clk);
        rx_valid = 1'b0;

        // Reset coincident with the 4th byte of a word must block the write.
        reset_dut();
        frame_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        send_frame(0, nacc);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        rst      = 1'b1;
        @(posedge clk);
        #2;
        check("rst_prio", 128'({i_mem_wr_en, words_loaded, rx_ready}), 128'({1'b0, 16'd0, 1'b1}));
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;

        // Reset after two payload bytes, then a full nominal frame.
        reset_dut();
        frame_q = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        send_frame(0, nacc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        build_frame(16'd2, 0, 1'b0);
        model();
        send_frame(2, nacc);
        repeat (3) @(negedge clk);
        compare_writes("midrst");
        check("midrst_done", 128'({load_done, cpu_rst_n, words_loaded}), 128'({1'b1, 1'b1, 16'd2}));

        // Reset while running returns every output to its reset value.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_reset_outputs("rst_in_run");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time loader that sits directly upstream of the single-cycle processor's instruction memory. It accepts a byte stream from a serial receiver, assembles little-endian 32-bit words, and writes them through the instruction memory write port. It validates an XOR checksum, then releases the processor from reset. The processor is held in reset for the entire load and stays there on any error.

## Interface
- `BUS_WIDTH`, 32: instruction word and address width.
- `DEPTH_WORDS`, 256: maximum loadable word count; must be ≤ 65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `i_mem_wr_en`  out  1  instruction memory write strobe, one-cycle pulse.
- `i_mem_wr_addr`  out  BUS_WIDTH  byte address of the write, word-aligned.
- `i_mem_wr_data`  out  BUS_WIDTH  instruction word to write.
- `cpu_rst_n`  out  1  processor reset, active-low; 0 holds the core.
- `load_done`  out  1  image loaded and checksum matched.
- `load_err`  out  1  bad count or checksum mismatch.
- `words_loaded`  out  16  number of words written so far.

## Operation
- **Handshake.** A byte transfers on a cycle with `rx_valid && rx_ready`. `rx_ready` is combinational from state: 1 in CNT_LO, CNT_HI, DATA and CSUM; 0 in RUN and ERROR. `rx_valid` may drop at any time; gaps are legal.
- **Frame format.**
  - Word count N as 2 bytes, low byte first.
  - N×4 payload bytes, each word little-endian (byte 0 = bits 7:0).
  - 1 checksum byte equal to the XOR of all payload bytes. Count bytes are excluded.
- **State CNT_LO.** Capture N[7:0], then go to CNT_HI.
- **State CNT_HI.** Capture N[15:8].
  - If N == 0 or N > DEPTH_WORDS, go to ERROR.
  - Otherwise go to DATA.
- **State DATA.**
  - A 2-bit byte index selects the lane in the word shift register.
  - Every payload byte is XORed into the running checksum.
  - On the 4th byte of a word, schedule a write of word k. Word k goes to address 4·k.
  - After the 4th byte of word N−1, go to CSUM.
- **State CSUM.** Compare the received byte with the running checksum. Equal: go to RUN. Unequal: go to ERROR.
- **State RUN.** `cpu_rst_n`=1 and `load_done`=1. The state is terminal until `rst`.
- **State ERROR.** `load_err`=1 and `cpu_rst_n`=0. The state is terminal until `rst`.
- **Counters.** `words_loaded` increments in the same cycle as each `i_mem_wr_en` pulse and saturates at N. The address is computed as {word index, 2'b00}, zero-extended to BUS_WIDTH. There is no wrap, because N ≤ DEPTH_WORDS is guaranteed.
- **Reset.**
  - State goes to CNT_LO; checksum, byte index and word index go to 0.
  - Reset values of every output: `i_mem_wr_en`=0, `i_mem_wr_addr`=0, `i_mem_wr_data`=0, `cpu_rst_n`=0, `load_done`=0, `load_err`=0, `words_loaded`=0. `rx_ready` follows state, so it is 1 in CNT_LO.
  - `rst` asserted mid-load abandons the partial word and frame. Memory contents already written are not cleared.

## Timing
- Write latency: `i_mem_wr_en`, `i_mem_wr_addr` and `i_mem_wr_data` are registered. They are valid for exactly one cycle, starting the cycle after the 4th byte is accepted.
- The checksum byte may be accepted in that same cycle, overlapping the last write. Both must complete correctly.
- State, `load_done` and `load_err` are registered.
  - `cpu_rst_n` rises the cycle after the matching checksum byte is accepted.
  - `load_err` rises the cycle after the rejecting byte is accepted.
- Back-to-back bytes are sustained at 1 byte/cycle with no stalls. `rx_ready` never drops inside a frame.
- Bytes presented in RUN or ERROR are not accepted (`rx_ready`=0) and have no effect.
- `rst` has priority over every transition in the same cycle, including a write that would otherwise have been scheduled.

## Test plan
- **Nominal load.** Stimulus: bytes 02 00, 93 00 50 00, 13 00 00 00, D0 at 1 byte/cycle. Required response:
  - Write 0x00500093 @0x0, then 0x00000013 @0x4.
  - `words_loaded`=2.
  - `cpu_rst_n`=1 and `load_done`=1 one cycle after D0.
- **Bad checksum.** Same frame with checksum D1 → both writes still occur, `load_err`=1, `cpu_rst_n` stays 0, `rx_ready`=0.
- **Bad count.** Count 00 00 → ERROR after the 2nd byte, no writes. Count equal to DEPTH_WORDS+1 → ERROR, no writes.
- **Gapped input.** Nominal frame with random 0–5 cycle `rx_valid` gaps → identical writes and final state. No byte is accepted while `rx_valid`=0.
- **Maximum image.** N=DEPTH_WORDS with an incrementing pattern → last write at address 4·(DEPTH_WORDS−1), `load_done`=1.
- **Reset mid-operation.**
  - `rst` after 2 payload bytes, then a full nominal frame → only the nominal writes occur, `load_done`=1.
  - `rst` in RUN → `cpu_rst_n`=0 and all outputs at reset values the next cycle.
